// File: rtl/prioritized_stream_arbiter_pkg.sv
// Shared types and helpers for the prioritized stream arbiter.
package prioritized_arbiter_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prioritized_stream_arbiter_if.sv
// Bundle of N input streams and one output stream around the arbiter.
interface prioritized_stream_arbiter_if
   import prioritized_arbiter_pkg::*;
#(
   parameter int data_width       = 8,
   parameter int number_of_inputs = 4
);

   // Handshake: a beat moves on a rising edge where valid && ready are both high;
   // a source holds valid and its payload stable until that edge, ready may change freely.
   logic [data_width-1:0]                    data [number_of_inputs-1:0];
   logic [number_of_inputs-1:0]              in_valid;
   logic [number_of_inputs-1:0]              in_last;
   logic [number_of_inputs-1:0]              in_ready;
   logic [data_width-1:0]                    demuxed_data;
   logic                                     out_valid;
   logic                                     out_last;
   logic [idx_width(number_of_inputs)-1:0]   out_source;
   logic                                     out_ready;
   arb_state_t                               arb_state;

   modport slave (
      input  data, in_valid, in_last, out_ready,
      output in_ready, demuxed_data, out_valid, out_last, out_source, arb_state
   );

   modport master (
      output data, in_valid, in_last, out_ready,
      input  in_ready, demuxed_data, out_valid, out_last, out_source, arb_state
   );

endinterface

// File: rtl/prioritized_stream_arbiter_priority_select.sv
// Combinational fixed-priority pick: request mask in, highest-level requester out.
module priority_select
   import prioritized_arbiter_pkg::*;
#(
   parameter int number_of_inputs = 4,
   parameter int priority_list [number_of_inputs-1:0] = '{3, 1, 2, 0}
) (
   input  logic [number_of_inputs-1:0]              req,
   output logic [number_of_inputs-1:0]              grant,
   output logic [idx_width(number_of_inputs)-1:0]   idx,
   output logic                                     any
);

   localparam int iw = idx_width(number_of_inputs);

   always_comb begin
      int best_level;
      grant      = '0;
      idx        = '0;
      any        = 1'b0;
      best_level = -1;
      for (int i = 0; i < number_of_inputs; i++) begin
         if (req[i] && (priority_list[i] > best_level)) begin
            best_level = priority_list[i];
            idx        = iw'(i);
            any        = 1'b1;
         end
      end
      if (any) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/prioritized_stream_arbiter.sv
// Packet-locking fixed-priority arbiter with optional aging and one registered output stage.
module prioritized_stream_arbiter
   import prioritized_arbiter_pkg::*;
#(
   parameter int data_width       = 8,
   parameter int number_of_inputs = 4,
   parameter int priority_list [number_of_inputs-1:0] = '{3, 1, 2, 0},
   parameter int starve_limit     = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   prioritized_stream_arbiter_if.slave   bus
);

   localparam int n  = number_of_inputs;
   localparam int iw = idx_width(n);
   localparam int cw = idx_width(starve_limit + 1);

   function automatic bit prio_is_perm();
      bit [n-1:0] seen;
      seen = '0;
      for (int i = 0; i < n; i++) begin
         if (priority_list[i] < 0 || priority_list[i] >= n || seen[priority_list[i]]) return 1'b0;
         seen[priority_list[i]] = 1'b1;
      end
      return 1'b1;
   endfunction

   if (n < 2) begin : g_bad_n
      $error("prioritized_stream_arbiter needs at least two inputs");
   end
   if (!prio_is_perm()) begin : g_bad_prio
      $error("priority_list must be a permutation of 0..number_of_inputs-1");
   end

   arb_state_t            state;
   logic [iw-1:0]         lock_idx;
   logic [cw-1:0]         age [n];
   logic [n-1:0]          starving, starve_grant, valid_grant, req_hot, in_ready;
   logic [iw-1:0]         starve_idx, valid_idx, winner;
   logic                  starve_any, valid_any, grant_ok, slot_free, xfer, xfer_last;
   logic                  out_valid_q, last_q;
   logic [data_width-1:0] data_q;
   logic [iw-1:0]         source_q;

   always_comb begin
      starving = '0;
      for (int i = 0; i < n; i++) begin
         starving[i] = (starve_limit > 0) && bus.in_valid[i] && (age[i] == cw'(starve_limit));
      end
   end

   priority_select #(.number_of_inputs(n), .priority_list(priority_list)) u_starve_sel (
      .req(starving), .grant(starve_grant), .idx(starve_idx), .any(starve_any)
   );

   priority_select #(.number_of_inputs(n), .priority_list(priority_list)) u_valid_sel (
      .req(bus.in_valid), .grant(valid_grant), .idx(valid_idx), .any(valid_any)
   );

   // A locked packet owns the port even while its source idles; starving inputs outrank the rest.
   always_comb begin
      winner   = valid_idx;
      req_hot  = valid_grant;
      grant_ok = valid_any;
      if (state == ARB_LOCKED) begin
         winner           = lock_idx;
         req_hot          = '0;
         req_hot[lock_idx] = 1'b1;
         grant_ok         = bus.in_valid[lock_idx];
      end else if (starve_any) begin
         winner  = starve_idx;
         req_hot = starve_grant;
      end
      slot_free = !out_valid_q || bus.out_ready;
      in_ready  = (rst_n && slot_free && grant_ok) ? req_hot : '0;
      xfer      = |in_ready;
      xfer_last = bus.in_last[winner];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ARB_IDLE;
         lock_idx    <= '0;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         last_q      <= 1'b0;
         source_q    <= '0;
      end else begin
         if (slot_free) begin
            out_valid_q <= xfer;
            if (xfer) begin
               data_q   <= bus.data[winner];
               last_q   <= xfer_last;
               source_q <= winner;
            end
         end
         case (state)
            ARB_IDLE: begin
               if (xfer && !xfer_last) begin
                  state    <= ARB_LOCKED;
                  lock_idx <= winner;
               end
            end
            ARB_LOCKED: begin
               if (xfer && xfer_last) state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   if (starve_limit > 0) begin : g_aging
      // Waiting time only restarts at packet end, so a partial packet keeps its seniority.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < n; i++) age[i] <= '0;
         end else begin
            for (int i = 0; i < n; i++) begin
               if (!bus.in_valid[i]) age[i] <= '0;
               else if (in_ready[i]) begin
                  if (bus.in_last[i]) age[i] <= '0;
               end else if (age[i] != cw'(starve_limit)) age[i] <= age[i] + cw'(1);
            end
         end
      end
   end else begin : g_no_aging
      always_comb begin
         for (int i = 0; i < n; i++) age[i] = '0;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.demuxed_data = data_q;
   assign bus.out_last     = last_q;
   assign bus.out_source   = source_q;
   assign bus.arb_state    = state;

endmodule

// File: tb/tb_prioritized_stream_arbiter.sv
// Bench: strict-priority and aging instances, reference model plus output scoreboard.
module tb_prioritized_stream_arbiter;
   import prioritized_arbiter_pkg::*;

   localparam int DW = 8;
   localparam int N  = 4;
   localparam int NK = 2;
   localparam int EW = 11;

   int level [N] = '{0, 2, 1, 3};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic [DW-1:0] data_t     [NK][N];
   logic [N-1:0]  in_valid_t [NK];
   logic [N-1:0]  in_last_t  [NK];
   logic [N-1:0]  in_ready_t [NK];
   logic [DW-1:0] dd_t       [NK];
   logic          ov_t       [NK];
   logic          ol_t       [NK];
   logic          or_t       [NK];
   logic [1:0]    os_t       [NK];

   logic [EW-1:0] exp_q [NK][$];
   logic [10:0]   src_q [NK][N][$];
   int            got_log [NK][$];
   int            want [$];
   int            m_owner [NK];
   int            m_wait [NK][N];
   bit            m_ov [NK];
   bit            stalled [NK];
   logic [EW-1:0] stall_beat [NK];
   int            checks = 0;
   int            errors = 0;
   int            ready_mode = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NK; k++) begin : g_dut
      prioritized_stream_arbiter_if #(.data_width(DW), .number_of_inputs(N)) sif ();
      for (genvar i = 0; i < N; i++) begin : g_in
         assign sif.data[i] = data_t[k][i];
      end
      assign sif.in_valid  = in_valid_t[k];
      assign sif.in_last   = in_last_t[k];
      assign sif.out_ready = or_t[k];
      assign in_ready_t[k] = sif.in_ready;
      assign dd_t[k]       = sif.demuxed_data;
      assign ov_t[k]       = sif.out_valid;
      assign ol_t[k]       = sif.out_last;
      assign os_t[k]       = sif.out_source;
      prioritized_stream_arbiter #(
         .data_width(DW), .number_of_inputs(N), .priority_list('{3, 1, 2, 0}), .starve_limit(k * 4)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .bus(sif)
      );
   end

   function automatic int lim_of(int k);
      return (k == 1) ? 4 : 0;
   endfunction

   task automatic check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int pick(int k, bit starve_only);
      int best = -1;
      for (int i = 0; i < N; i++) begin
         if (in_valid_t[k][i] && (!starve_only || (lim_of(k) > 0 && m_wait[k][i] >= lim_of(k)))
             && (best < 0 || level[i] > level[best])) best = i;
      end
      return best;
   endfunction

   task automatic model_reset(int k);
      m_owner[k] = -1;
      m_ov[k]    = 1'b0;
      for (int i = 0; i < N; i++) m_wait[k][i] = 0;
      exp_q[k].delete();
   endtask

   // Predicts this cycle's grant from the rules, checks in_ready/out_valid, queues the beat.
   task automatic model_step(int k);
      int cand;
      int lim;
      bit sf;
      bit lst;
      logic [N-1:0] exp_ir;
      lim = lim_of(k);
      if (!rst_n) begin
         check($sformatf("rst_in_ready%0d", k), 32'(in_ready_t[k]), 0);
         check($sformatf("rst_out_valid%0d", k), 32'(ov_t[k]), 0);
         check($sformatf("rst_data%0d", k), 32'(dd_t[k]), 0);
         check($sformatf("rst_source%0d", k), 32'(os_t[k]), 0);
         check($sformatf("rst_last%0d", k), 32'(ol_t[k]), 0);
         return;
      end
      check($sformatf("out_valid%0d", k), 32'(ov_t[k]), 32'(m_ov[k]));
      sf = !m_ov[k] || or_t[k];
      cand = -1;
      if (m_owner[k] >= 0) begin
         if (in_valid_t[k][m_owner[k]]) cand = m_owner[k];
      end else begin
         cand = pick(k, 1'b1);
         if (cand < 0) cand = pick(k, 1'b0);
      end
      if (!sf) cand = -1;
      exp_ir = '0;
      if (cand >= 0) exp_ir[cand] = 1'b1;
      check($sformatf("in_ready%0d", k), 32'(in_ready_t[k]), 32'(exp_ir));
      if (cand >= 0) begin
         lst = in_last_t[k][cand];
         exp_q[k].push_back({2'(cand), lst, data_t[k][cand]});
         if (m_owner[k] < 0 && !lst) m_owner[k] = cand;
         else if (lst) m_owner[k] = -1;
      end
      for (int i = 0; i < N; i++) begin
         if (!in_valid_t[k][i]) m_wait[k][i] = 0;
         else if (i == cand) begin
            if (in_last_t[k][i]) m_wait[k][i] = 0;
         end else if (m_wait[k][i] < lim) m_wait[k][i]++;
      end
      if (sf) m_ov[k] = (cand >= 0);
   endtask

   task automatic apply_drives();
      logic [10:0] f;
      for (int k = 0; k < NK; k++) begin
         for (int i = 0; i < N; i++) begin
            if (src_q[k][i].size() == 0) begin
               in_valid_t[k][i] = 1'b0;
               in_last_t[k][i]  = 1'b0;
               data_t[k][i]     = '0;
            end else begin
               f = src_q[k][i][0];
               data_t[k][i]    = f[7:0];
               in_last_t[k][i] = f[8];
               if (f[10:9] != 2'd0) begin
                  in_valid_t[k][i] = 1'b0;
                  src_q[k][i][0]   = {f[10:9] - 2'd1, f[8:0]};
               end else in_valid_t[k][i] = 1'b1;
            end
         end
         or_t[k] = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic cycle();
      logic [N-1:0] acc [NK];
      apply_drives();
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
         model_step(k);
         acc[k] = in_valid_t[k] & in_ready_t[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NK; k++)
         for (int i = 0; i < N; i++)
            if (acc[k][i] && src_q[k][i].size() > 0) src_q[k][i].delete(0);
   endtask

   task automatic load_pkt(int i, int len, int d0, int gap_at, int gap_len);
      for (int k = 0; k < NK; k++)
         for (int b = 0; b < len; b++)
            src_q[k][i].push_back({2'((b == gap_at) ? gap_len : 0), (b == len - 1), 8'(d0 + b)});
   endtask

   function automatic bit busy();
      for (int k = 0; k < NK; k++) begin
         if (exp_q[k].size() != 0 || ov_t[k]) return 1'b1;
         for (int i = 0; i < N; i++) if (src_q[k][i].size() != 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drain(string name, int budget);
      int c = 0;
      while (busy() && c < budget) begin
         cycle();
         c++;
      end
      check({name, "_drain_busy"}, 32'(busy()), 0);
      cycle();
   endtask

   task automatic want_rep(int src, int cnt);
      for (int j = 0; j < cnt; j++) want.push_back(src);
   endtask

   task automatic check_log(int k, string name);
      check($sformatf("%s_count%0d", name, k), got_log[k].size(), want.size());
      for (int j = 0; j < want.size() && j < got_log[k].size(); j++)
         check($sformatf("%s_src%0d_%0d", name, k, j), got_log[k][j], want[j]);
      got_log[k].delete();
   endtask

   // Output scoreboard: every accepted beat must match the oldest predicted beat.
   initial begin
      logic [EW-1:0] cur;
      logic [EW-1:0] expv;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NK; k++) begin
            if (!rst_n) stalled[k] = 1'b0;
            else if (ov_t[k]) begin
               cur = {os_t[k], ol_t[k], dd_t[k]};
               if (stalled[k]) check($sformatf("stall_hold%0d", k), 32'(cur), 32'(stall_beat[k]));
               if (or_t[k]) begin
                  stalled[k] = 1'b0;
                  if (exp_q[k].size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL beat_unexpected%0d got %0h expected none", k, cur);
                  end else begin
                     expv = exp_q[k].pop_front();
                     check($sformatf("beat%0d", k), 32'(cur), 32'(expv));
                  end
                  got_log[k].push_back(int'(os_t[k]));
               end else begin
                  stalled[k]    = 1'b1;
                  stall_beat[k] = cur;
               end
            end else stalled[k] = 1'b0;
         end
      end
   end

   initial begin
      for (int k = 0; k < NK; k++) begin
         model_reset(k);
         stalled[k] = 1'b0;
      end
      rst_n = 1'b0;
      ready_mode = 0;
      repeat (3) cycle();
      rst_n = 1'b1;
      cycle();

      // single beats, strict order by level
      load_pkt(3, 1, 7, 9, 0);
      load_pkt(1, 1, 3, 9, 0);
      drain("t1", 50);
      want.delete(); want_rep(3, 1); want_rep(1, 1);
      check_log(0, "t1"); check_log(1, "t1");

      // packet lock blocks a higher-level newcomer
      load_pkt(1, 3, 8'h10, 9, 0);
      cycle();
      load_pkt(3, 1, 8'h20, 9, 0);
      drain("t2", 50);
      want.delete(); want_rep(1, 3); want_rep(3, 1);
      check_log(0, "t2"); check_log(1, "t2");

      // downstream stall
      load_pkt(2, 3, 8'h30, 9, 0);
      load_pkt(0, 1, 8'h40, 9, 0);
      cycle();
      ready_mode = 2;
      repeat (4) cycle();
      ready_mode = 0;
      drain("t3", 50);
      want.delete(); want_rep(2, 3); want_rep(0, 1);
      check_log(0, "t3"); check_log(1, "t3");

      // aging against a continuously requesting high-level input
      for (int j = 0; j < 8; j++) load_pkt(3, 1, 8'h50 + j, 9, 0);
      for (int j = 0; j < 2; j++) load_pkt(0, 1, 8'h60 + j, 9, 0);
      drain("t4", 50);
      want.delete(); want_rep(3, 8); want_rep(0, 2);
      check_log(0, "t4");
      want.delete(); want_rep(3, 4); want_rep(0, 1); want_rep(3, 4); want_rep(0, 1);
      check_log(1, "t4");

      // locked owner idles mid-packet
      load_pkt(1, 5, 8'h70, 2, 2);
      cycle();
      load_pkt(3, 1, 8'h80, 9, 0);
      drain("t5", 60);
      want.delete(); want_rep(1, 5); want_rep(3, 1);
      check_log(0, "t5"); check_log(1, "t5");

      // reset while locked with a beat on the output
      load_pkt(1, 4, 8'h90, 9, 0);
      cycle();
      cycle();
      ready_mode = 2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < NK; k++) begin
         check($sformatf("t6_out_valid%0d", k), 32'(ov_t[k]), 0);
         check($sformatf("t6_in_ready%0d", k), 32'(in_ready_t[k]), 0);
         model_reset(k);
         for (int i = 0; i < N; i++) src_q[k][i].delete();
         got_log[k].delete();
      end
      for (int i = 0; i < N; i++) load_pkt(i, 1, 2 * i + 1, 9, 0);
      ready_mode = 0;
      repeat (2) cycle();
      rst_n = 1'b1;
      drain("t6", 50);
      want.delete(); want_rep(3, 1); want_rep(1, 1); want_rep(2, 1); want_rep(0, 1);
      check_log(0, "t6"); check_log(1, "t6");

      // randomized packets, gaps and backpressure
      ready_mode = 1;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < N; i++) begin
            int npk;
            npk = $urandom_range(2, 5);
            for (int p = 0; p < npk; p++) begin
               int len;
               len = $urandom_range(1, 4);
               load_pkt(i, len, $urandom_range(0, 255), $urandom_range(0, len), $urandom_range(1, 3));
            end
         end
         drain("rand", 2000);
         for (int k = 0; k < NK; k++) got_log[k].delete();
      end
      ready_mode = 0;

      for (int k = 0; k < NK; k++) check($sformatf("final_exp_q%0d", k), exp_q[k].size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
